sm_ex_commit_buf: RTL
=====================

Name: sm_ex_commit_buf

Overview:
Execute-to-commit buffer that sits directly downstream of the 16-bit sign-magnitude add/sub unit in the ALU path. It captures the combinational result and flags with a valid/ready handshake and normalises negative zero. It holds up to two results in a skid buffer, maintains the architectural NZCV flag register, and provides a forwarding tap for the decode stage.

Parameters:
N, 32, datapath width; the sign-magnitude value occupies bits [15:0], and bits [N-1:16] are zero.
RD_W, 4, destination register index width.

Ports:
clk  in  1  clock; all state changes on rising edge
rst  in  1  synchronous reset, active-low
in_valid  in  1  upstream result valid
in_ready  out  1  buffer can accept this cycle
in_result  in  N  sign-magnitude result (bit 15 = sign, [14:0] = magnitude)
in_cout  in  1  carry/borrow from magnitude path
in_zero  in  1  result zero flag
in_overflow  in  1  overflow flag
in_neg  in  1  negative flag
in_rd  in  RD_W  destination register
in_we  in  1  instruction writes register file
in_setflags  in  1  instruction updates NZCV on commit
flush  in  1  discard all buffered entries
out_valid  out  1  head entry valid
out_ready  in  1  commit stage accepts head
out_result  out  N  head result
out_rd  out  RD_W  head destination
out_we  out  1  head write enable
flags  out  4  architectural {N,Z,C,V}
fwd_valid  out  1  forwarding hit available (newest valid entry with we=1)
fwd_rd  out  RD_W  forwarded destination
fwd_result  out  N  forwarded value

Behaviour:
- Reset (rst=0 at clock edge):
  - count=0, both entries cleared, flags=4'b0000.
  - out_valid=0, fwd_valid=0.
  - in_ready=1 in the cycle after reset.
  - Reset mid-transfer drops everything; nothing is committed.
- Storage: 2-entry FIFO (head, tail), count in {0,1,2}.
  - Each entry holds result, rd, we, setflags, N, Z, C, V.
- in_ready is a function of registered count only: in_ready = (count<2). It has no combinational path from out_ready.
- Accept occurs when in_valid & in_ready. Commit occurs when out_valid & out_ready.
  - Both in the same cycle: count unchanged, entries shift correctly.
  - Accept with count=2 is impossible, because in_ready=0.
- Latency: an accepted entry appears on out_* the next cycle when the buffer was empty.
- Negative-zero normalisation on capture: if in_result[14:0]==0, store result with bit15=0, N=0, Z=1, whatever the upstream sign/zero bits.
  - Bits [N-1:16] of the stored result are forced to 0.
  - Otherwise N=in_result[15], Z=in_zero.
- Flag commit:
  - On a commit of an entry with setflags=1, flags <= {N,Z,C,V} of that entry on the same edge.
  - Entries with setflags=0 leave flags unchanged.
  - Flags never update on accept or flush.
- Forwarding (combinational from storage): fwd_* selects the tail entry if valid and we=1, else the head entry if valid and we=1, else fwd_valid=0.
  - fwd_rd and fwd_result are 0 when fwd_valid=0.
- flush (highest priority after reset):
  - At the edge, count <= 0 and any same-cycle accept is dropped.
  - A same-cycle commit still counts: the head is considered consumed and its flags are applied if setflags=1.
  - flags are otherwise preserved.
- out_* hold stable while out_valid=1 and out_ready=0.
- out_result, out_rd and out_we are 0 when empty.

Test Plan:
- Reset, then accept result 0x0000_8003 (setflags=1, neg=1, rd=5, we=1), with out_ready=1 -> next cycle out_valid=1, out_result=0x0000_8003, out_rd=5; the following edge gives flags=4'b1000.
- Negative zero: in_result=0x0000_8000, in_zero=0, in_neg=1 -> stored/out_result=0x0000_0000; after commit with setflags=1, flags=4'b0100.
- Backpressure: hold out_ready=0 and offer 3 results (0x1,0x2,0x3) -> in_ready drops after 2 accepts and 0x3 is held upstream. Then out_ready=1 -> commits in order 0x1,0x2,0x3 with no loss or duplication.
- Simultaneous accept+commit at count=1 for 10 cycles -> count stays 1, in_ready stays 1, output order is preserved.
- Forwarding: head rd=2 (we=1, 0x0000_0007), tail rd=3 (we=0) -> fwd_valid=1, fwd_rd=2, fwd_result=0x7. Once the tail has we=1 with rd=3 -> fwd_rd=3.
- Flush with count=2 and flags=4'b0010 -> next cycle out_valid=0, fwd_valid=0, in_ready=1, flags still 4'b0010. Then assert rst=0 for one edge -> flags=0.

Source files
------------

// File: rtl/sm_ex_commit_buf_if.sv
// sm_ex_commit_buf_if: upstream capture, commit and forwarding signals of the commit buffer
interface sm_ex_commit_buf_if #(parameter int N = 32, parameter int RD_W = 4);
  logic            in_valid, in_ready, in_cout, in_zero, in_overflow, in_neg, in_we, in_setflags;
  logic [N-1:0]    in_result, out_result, fwd_result;
  logic [RD_W-1:0] in_rd, out_rd, fwd_rd;
  logic            flush, out_valid, out_ready, out_we, fwd_valid;
  logic [3:0]      flags;
  modport master (
    output in_valid, in_result, in_cout, in_zero, in_overflow, in_neg, in_rd, in_we, in_setflags,
           flush, out_ready,
    input  in_ready, out_valid, out_result, out_rd, out_we, flags, fwd_valid, fwd_rd, fwd_result
  );
  modport slave (
    input  in_valid, in_result, in_cout, in_zero, in_overflow, in_neg, in_rd, in_we, in_setflags,
           flush, out_ready,
    output in_ready, out_valid, out_result, out_rd, out_we, flags, fwd_valid, fwd_rd, fwd_result
  );
endinterface

// File: rtl/sm_ex_commit_buf.sv
// sm_ex_commit_buf: two-entry execute-to-commit skid buffer with NZCV commit and forwarding tap
module sm_ex_commit_buf #(parameter int N = 32, parameter int RD_W = 4) (
  input logic clk,
  input logic rst,
  sm_ex_commit_buf_if.slave bus
);
  typedef struct packed {
    logic [N-1:0]    result;
    logic [RD_W-1:0] rd;
    logic            we, sf, n, z, c, v;
  } ent_t;
  ent_t       head_q, head_d, tail_q, tail_d, new_e;
  logic [1:0] count_q, count_d;
  logic [3:0] flags_q, flags_d;
  logic       mz, accept, commit, fwd_t, fwd_h, unused_hi;
  assign unused_hi = ^bus.in_result[N-1:16];
  always_comb begin
    mz = bus.in_result[14:0] == '0;
    new_e.result = {{(N-16){1'b0}}, ~mz & bus.in_result[15], bus.in_result[14:0]};
    new_e.rd = bus.in_rd;
    new_e.we = bus.in_we;
    new_e.sf = bus.in_setflags;
    new_e.n = ~mz & bus.in_result[15];
    new_e.z = mz | bus.in_zero;
    new_e.c = bus.in_cout;
    new_e.v = bus.in_overflow;
    accept = bus.in_valid & (count_q != 2'd2);
    commit = bus.out_ready & (count_q != 2'd0);
    head_d = head_q;
    tail_d = tail_q;
    count_d = count_q;
    flags_d = commit & head_q.sf ? {head_q.n, head_q.z, head_q.c, head_q.v} : flags_q;
    if (bus.flush) count_d = 2'd0;
    else if (commit & accept) begin
      head_d = count_q == 2'd2 ? tail_q : new_e;
      tail_d = new_e;
    end else if (commit) begin
      head_d = tail_q;
      count_d = count_q - 2'd1;
    end else if (accept) begin
      head_d = count_q == 2'd0 ? new_e : head_q;
      tail_d = count_q == 2'd0 ? tail_q : new_e;
      count_d = count_q + 2'd1;
    end
  end
  always_ff @(posedge clk)
    if (!rst) begin
      head_q <= '0;
      tail_q <= '0;
      count_q <= '0;
      flags_q <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      count_q <= count_d;
      flags_q <= flags_d;
    end
  assign fwd_t = (count_q == 2'd2) & tail_q.we;
  assign fwd_h = (count_q != 2'd0) & head_q.we;
  assign bus.in_ready = count_q != 2'd2;
  assign bus.out_valid = count_q != 2'd0;
  assign bus.out_result = bus.out_valid ? head_q.result : '0;
  assign bus.out_rd = bus.out_valid ? head_q.rd : '0;
  assign bus.out_we = bus.out_valid & head_q.we;
  assign bus.flags = flags_q;
  assign bus.fwd_valid = fwd_t | fwd_h;
  assign bus.fwd_rd = fwd_t ? tail_q.rd : fwd_h ? head_q.rd : '0;
  assign bus.fwd_result = fwd_t ? tail_q.result : fwd_h ? head_q.result : '0;
endmodule
